// File: rtl/demux_latch_pkg.sv
// demux_pkg: shared state encoding, slot indices and write-counter constants for demux_latch
package demux_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, LOCKOUT} state_t;
  localparam logic [1:0] SLOT_U = 2'd0;
  localparam logic [1:0] SLOT_V = 2'd1;
  localparam logic [1:0] SLOT_W = 2'd2;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_SAT = 4'd15;
  // SEL[1] has priority so 1x always lands in W, mirroring the read-side mux
  function automatic logic [1:0] sel_to_slot(input logic [1:0] sel);
    return sel[1] ? SLOT_W : (sel[0] ? SLOT_V : SLOT_U);
  endfunction
endpackage

// File: rtl/demux_latch_sync_bit.sv
// sync_bit: multi-flop synchroniser for a single asynchronous level
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;
  always_ff @(posedge clk)
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[STAGES-2:0], i_d};
  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/demux_latch.sv
// demux_latch: debounced one-write-per-press 1-to-3 demux into holding registers U/V/W
module demux_latch
  import demux_pkg::*;
#(
  parameter int WIDTH          = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCKOUT_CYCLES = 4
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [1:0]       SEL,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  input  logic             CLEAR,
  output logic [WIDTH-1:0] U,
  output logic [WIDTH-1:0] V,
  output logic [WIDTH-1:0] W,
  output logic [2:0]       VALID,
  output logic             ACK,
  output logic [CNT_W-1:0] WR_COUNT
);
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_INIT = LW'(LOCKOUT_CYCLES - 1);

  state_t           r_state;
  logic [LW-1:0]    r_lock;
  logic [WIDTH-1:0] r_slot [3];
  logic [2:0]       r_valid;
  logic             r_ack;
  logic [CNT_W-1:0] r_cnt;
  logic             w_ld_s;
  logic             w_commit;
  logic [1:0]       w_idx;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(CLOCK_50),
    .rst(RESET),
    .i_d(LOAD),
    .o_q(w_ld_s)
  );

  assign w_commit = (r_state == IDLE) && w_ld_s;
  assign w_idx    = sel_to_slot(SEL);

  // a high ld_s during lockout reloads the gap so bounces extend it
  always_ff @(posedge CLOCK_50)
    if (RESET) begin
      r_state <= IDLE;
      r_lock  <= '0;
    end else begin
      case (r_state)
        IDLE:    if (w_ld_s) r_state <= HOLD;
        HOLD:    if (!w_ld_s) begin
                   r_state <= LOCKOUT;
                   r_lock  <= LOCK_INIT;
                 end
        LOCKOUT: if (w_ld_s) r_lock <= LOCK_INIT;
                 else if (r_lock == '0) r_state <= IDLE;
                 else r_lock <= r_lock - LW'(1);
        default: r_state <= IDLE;
      endcase
    end

  // CLEAR beats a coincident commit on the slots, but the press is still consumed
  always_ff @(posedge CLOCK_50)
    if (RESET) begin
      r_slot[0] <= '0;
      r_slot[1] <= '0;
      r_slot[2] <= '0;
      r_valid   <= '0;
      r_ack     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_ack <= w_commit;
      if (w_commit && r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
      if (CLEAR) begin
        r_slot[0] <= '0;
        r_slot[1] <= '0;
        r_slot[2] <= '0;
        r_valid   <= '0;
      end else if (w_commit) begin
        r_slot[w_idx]  <= DIN;
        r_valid[w_idx] <= 1'b1;
      end
    end

  assign U        = r_slot[SLOT_U];
  assign V        = r_slot[SLOT_V];
  assign W        = r_slot[SLOT_W];
  assign VALID    = r_valid;
  assign ACK      = r_ack;
  assign WR_COUNT = r_cnt;
endmodule

// File: tb/tb_demux_latch.sv
// tb_demux_latch: directed table, corner sequences and random traffic against a press-level model
module tb_demux_latch;
  localparam int WIDTH = 2;
  localparam int SS    = 2;
  localparam int LC    = 4;
  localparam int GAP   = SS + LC + SS + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic             clear = 1'b0;
  logic [1:0]       sel = '0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] u, v, w;
  logic [2:0]       valid;
  logic             ack;
  logic [3:0]       wr_count;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] m_slot [3] = '{default: '0};
  logic [2:0]       m_valid = '0;
  logic             m_ack = 1'b0;
  int               m_cnt = 0;
  bit               m_armed = 1'b1;
  bit               m_released = 1'b0;
  int               m_quiet = 0;
  bit               m_hist [SS] = '{default: 1'b0};

  typedef struct {
    logic [1:0]       sel;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] eu, ev, ew;
    logic [2:0]       evalid;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  demux_latch #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .LOCKOUT_CYCLES(LC)) dut (
    .CLOCK_50(clk), .RESET(rst), .SEL(sel), .DIN(din), .LOAD(load), .CLEAR(clear),
    .U(u), .V(v), .W(w), .VALID(valid), .ACK(ack), .WR_COUNT(wr_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Press-level model: a press is taken only when armed; re-arming needs a release
  // followed by LC consecutive quiet ld_s samples (any high restarts the count).
  task automatic model_edge();
    bit s;
    bit commit;
    int idx;
    if (rst) begin
      m_slot = '{default: '0};
      m_valid = '0; m_ack = 1'b0; m_cnt = 0;
      m_armed = 1'b1; m_released = 1'b0; m_quiet = 0;
      m_hist = '{default: 1'b0};
      return;
    end
    s = m_hist[SS-1];
    commit = 1'b0;
    if (m_armed) begin
      if (s) begin commit = 1'b1; m_armed = 1'b0; m_released = 1'b0; end
    end else if (!m_released) begin
      if (!s) begin m_released = 1'b1; m_quiet = 0; end
    end else begin
      m_quiet = s ? 0 : m_quiet + 1;
      if (m_quiet == LC) m_armed = 1'b1;
    end
    m_ack = commit;
    if (commit) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    if (clear) begin
      m_slot = '{default: '0};
      m_valid = '0;
    end else if (commit) begin
      idx = sel[1] ? 2 : (sel[0] ? 1 : 0);
      m_slot[idx] = din;
      m_valid[idx] = 1'b1;
    end
    for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = load;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", {u, v, w, valid, ack, wr_count},
        {m_slot[0], m_slot[1], m_slot[2], m_valid, m_ack, 4'(m_cnt)});
  endtask

  task automatic press(input logic [1:0] s, input logic [WIDTH-1:0] d, input int hold);
    sel = s; din = d; load = 1'b1;
    repeat (hold) step();
    load = 1'b0;
    repeat (GAP) step();
  endtask

  initial begin
    int base;
    int n;
    tbl[0] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 3'b010};
    tbl[1] = '{2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 3'b110};
    tbl[2] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 3'b110};
    tbl[3] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 3'b111};
    tbl[4] = '{2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 3'b111};

    repeat (2) step();
    chk("reset_state", {u, v, w, valid, ack, wr_count}, 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      press(tbl[i].sel, tbl[i].din, 3);
      chk("tbl_slots", {u, v, w, valid}, {tbl[i].eu, tbl[i].ev, tbl[i].ew, tbl[i].evalid});
      chk("tbl_count", wr_count, 64'(i + 1));
    end

    // bounce inside lockout: only the first edge writes
    base = wr_count;
    sel = 2'b00; din = 2'b01; load = 1'b1;
    repeat (3) step();
    load = 1'b0; repeat (2) step();
    load = 1'b1; repeat (2) step();
    load = 1'b0; repeat (2) step();
    load = 1'b1; step();
    load = 1'b0; repeat (GAP) step();
    chk("bounce_one_write", wr_count, 64'(base + 1));
    chk("bounce_u", u, 64'(2'b01));
    press(2'b00, 2'b10, 2);
    chk("second_press", {u, wr_count}, {2'b10, 4'(base + 2)});

    // CLEAR on the commit edge
    base = wr_count;
    sel = 2'b00; din = 2'b11; load = 1'b1;
    repeat (2) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_u", u, 64'd0);
    chk("clear_valid", valid, 64'd0);
    chk("clear_ack", ack, 64'd1);
    chk("clear_count", wr_count, 64'(base + 1));
    load = 1'b0;
    repeat (GAP) step();

    // reset during HOLD with LOAD still held
    sel = 2'b01; din = 2'b11; load = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("rst_hold_outputs", {u, v, w, valid, ack, wr_count}, 64'd0);
    rst = 1'b0;
    n = 0;
    while (ack !== 1'b1 && n < 10) begin step(); n++; end
    chk("rst_recommit_latency", n, 64'(SS + 1));
    chk("rst_recommit", {v, valid, wr_count}, {2'b11, 3'b010, 4'd1});
    load = 1'b0;
    repeat (GAP) step();

    for (int i = 0; i < 17; i++) press(2'($urandom), 2'($urandom), 1 + $urandom_range(0, 3));
    chk("saturate", wr_count, 64'd15);

    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) load = ~load;
      sel = 2'($urandom);
      din = 2'($urandom);
      clear = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; clear = 1'b0; load = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
